// File: rtl/fcs_gen.sv
// Ethernet FCS (CRC-32, reflected 0xEDB88320) generator for a 2-bit RMII-style stream.
// Define FCS_CHECK_EN to add the fcs_ok residue-check output.
module fcs_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic [31:0] cksum,
`ifdef FCS_CHECK_EN
    output logic        fcs_ok,
`endif
    output logic        axiov
);

    localparam int unsigned CRC_W = 32;
    localparam logic [CRC_W-1:0] POLY    = 32'hEDB8_8320;
    localparam logic [CRC_W-1:0] INIT    = 32'hFFFF_FFFF;
    localparam logic [CRC_W-1:0] RESIDUE = 32'hDEBB_20E3;

    logic [CRC_W-1:0] crc, crc_nxt;
    logic [CRC_W-1:0] cksum_nxt;
    logic             in_frame, in_frame_nxt;
    logic             axiov_nxt;
`ifdef FCS_CHECK_EN
    logic             fcs_ok_nxt;
`endif

    // One serial LSB-first CRC-32 step.
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
        return (c >> 1) ^ ((c[0] ^ b) ? POLY : CRC_W'(0));
    endfunction

    // Next-state: absorb dibits while valid, publish complemented CRC on the first idle edge.
    always_comb begin
        crc_nxt      = crc;
        in_frame_nxt = in_frame;
        cksum_nxt    = cksum;
        axiov_nxt    = 1'b0;
`ifdef FCS_CHECK_EN
        fcs_ok_nxt   = fcs_ok;
`endif
        if (axiiv) begin
            crc_nxt      = crc_step(crc_step(crc, axiid[0]), axiid[1]);
            in_frame_nxt = 1'b1;
        end else if (in_frame) begin
            cksum_nxt    = ~crc;
            axiov_nxt    = 1'b1;
            crc_nxt      = INIT;
            in_frame_nxt = 1'b0;
`ifdef FCS_CHECK_EN
            fcs_ok_nxt   = (crc == RESIDUE);
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            crc      <= INIT;
            in_frame <= 1'b0;
            cksum    <= '0;
            axiov    <= 1'b0;
`ifdef FCS_CHECK_EN
            fcs_ok   <= 1'b0;
`endif
        end else begin
            crc      <= crc_nxt;
            in_frame <= in_frame_nxt;
            cksum    <= cksum_nxt;
            axiov    <= axiov_nxt;
`ifdef FCS_CHECK_EN
            fcs_ok   <= fcs_ok_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_fcs_gen.sv
// Directed self-checking bench for fcs_gen; exercises fcs_ok when FCS_CHECK_EN is defined.
module tb_fcs_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        axiiv;
    logic [1:0]  axiid;
    logic [31:0] cksum;
    logic        axiov;
`ifdef FCS_CHECK_EN
    logic        fcs_ok;
`endif

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [7:0] fbuf[$];

    fcs_gen dut (
        .clk   (clk),
        .rst   (rst),
        .axiiv (axiiv),
        .axiid (axiid),
        .cksum (cksum),
`ifdef FCS_CHECK_EN
        .fcs_ok(fcs_ok),
`endif
        .axiov (axiov)
    );

    always #5 clk = ~clk;

    // axiov lasts one full cycle, so sampling once per negedge counts each pulse once.
    always @(negedge clk) if (axiov === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    // Reference CRC-32, byte-oriented, over the whole buffer.
    function automatic logic [31:0] ref_crc(input logic [7:0] q[$]);
        logic [31:0] c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {24'h0, q[i]};
            for (int k = 0; k < 8; k++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic load_str(input string s);
        fbuf.delete();
        for (int i = 0; i < s.len(); i++) fbuf.push_back(s[i]);
    endtask

    // Drives fbuf[0..nbytes-1] as dibits (LSB dibit first), starting at a negedge.
    task automatic drive_bytes(input int nbytes);
        for (int i = 0; i < nbytes; i++) begin
            for (int d = 0; d < 4; d++) begin
                axiiv = 1'b1;
                axiid = 2'(fbuf[i] >> (2 * d));
                @(negedge clk);
            end
        end
        axiiv = 1'b0;
        axiid = 2'b11;
    endtask

    // Sends the whole buffer and checks the single-cycle result pulse.
    task automatic send_and_check(input string tag, input logic [31:0] exp);
        int p0;
        p0 = pulses;
        drive_bytes(fbuf.size());
        @(posedge clk); #1;
        check({tag, "_axiov_hi"}, 32'(axiov), 32'd1);
        check({tag, "_cksum"}, cksum, exp);
        @(posedge clk); #1;
        check({tag, "_axiov_lo"}, 32'(axiov), 32'd0);
        check({tag, "_cksum_hold"}, cksum, exp);
        @(negedge clk);
        check({tag, "_pulses"}, 32'(pulses - p0), 32'd1);
    endtask

    initial begin
        rst   = 1'b0;
        axiiv = 1'b0;
        axiid = 2'b00;
        repeat (3) @(negedge clk);
        check("rst_axiov", 32'(axiov), 32'd0);
        check("rst_cksum", cksum, 32'h0);
        rst = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_pulses", 32'(pulses), 32'd0);
        check("idle_cksum", cksum, 32'h0);

        load_str("123456789");
        send_and_check("check9", 32'hCBF4_3926);

        fbuf.delete(); fbuf.push_back(8'h00);
        send_and_check("byte00", 32'hD202_EF8D);
        fbuf.delete(); fbuf.push_back(8'h61);
        send_and_check("byte61", 32'hE8B7_BE43);

        // Abort mid-frame with reset, then a clean frame.
        pulses = 0;
        load_str("123456789");
        drive_bytes(5);
        axiiv = 1'b1;
        axiid = 2'b01;
        rst = 1'b0;
        @(negedge clk);
        axiiv = 1'b0;
        rst = 1'b1;
        check("abort_cksum", cksum, 32'h0);
        @(negedge clk);
        send_and_check("after_abort", 32'hCBF4_3926);
        check("abort_total_pulses", 32'(pulses), 32'd1);

        // Frame with appended FCS: complement of the good residue.
        load_str("123456789");
        fbuf.push_back(8'h26); fbuf.push_back(8'h39);
        fbuf.push_back(8'hF4); fbuf.push_back(8'hCB);
        send_and_check("good_fcs", 32'h2144_DF1C);
`ifdef FCS_CHECK_EN
        check("fcs_ok_good", 32'(fcs_ok), 32'd1);
`endif
        fbuf[fbuf.size()-1] = fbuf[fbuf.size()-1] ^ 8'h01;
        send_and_check("bad_fcs", ref_crc(fbuf));
`ifdef FCS_CHECK_EN
        check("fcs_ok_bad", 32'(fcs_ok), 32'd0);
`endif

        fbuf.delete();
        for (int i = 0; i < 21; i++) fbuf.push_back(8'(i * 37 + 5));
        send_and_check("frame21", ref_crc(fbuf));

        repeat (5) @(negedge clk);
        check("tail_axiov", 32'(axiov), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
